// File: rtl/stage_seq_monitor_if.sv
// Bundle of stage strobes, decode fields and monitor results for stage_seq_monitor.
// master drives the strobes (stage-clock generator side); slave is the monitor.
interface stage_seq_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;

    logic               if_clk;
    logic               id_clk;
    logic               ex_clk;
    logic               mem_clk;
    logic               wb_clk;
    logic [OP_W-1:0]    op_code;
    logic [FUNCT_W-1:0] funct;
    logic               busy;
    logic               retire;
    logic [CNT_W-1:0]   retire_count;
    logic [2:0]         inst_class;
    logic [3:0]         last_cpi;
    logic               err;
    logic [2:0]         err_code;

    modport master (
        output if_clk, id_clk, ex_clk, mem_clk, wb_clk, op_code, funct,
        input  busy, retire, retire_count, inst_class, last_cpi, err, err_code
    );

    modport slave (
        input  if_clk, id_clk, ex_clk, mem_clk, wb_clk, op_code, funct,
        output busy, retire, retire_count, inst_class, last_cpi, err, err_code
    );
endinterface

// File: rtl/stage_seq_monitor.sv
// Passive checker of the multicycle core's one-hot stage strobes: rebuilds each
// instruction's stage order, retires legal ones with their CPI, latches the first violation.
module stage_seq_monitor #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 8
) (
    input logic               clk,
    input logic               rst,
    stage_seq_monitor_if.slave bus
);
    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] CL_LOAD   = 3'd0;
    localparam logic [2:0] CL_STORE  = 3'd1;
    localparam logic [2:0] CL_ALU    = 3'd2;
    localparam logic [2:0] CL_BRANCH = 3'd3;
    localparam logic [2:0] CL_JUMP   = 3'd4;
    localparam logic [2:0] CL_LUI    = 3'd5;

    localparam logic [1:0] ST_EX  = 2'd0;
    localparam logic [1:0] ST_MEM = 2'd1;
    localparam logic [1:0] ST_WB  = 2'd2;

    localparam logic [2:0] E_MULTI_HOT = 3'd1;
    localparam logic [2:0] E_BAD_ORDER = 3'd2;
    localparam logic [2:0] E_TIMEOUT   = 3'd3;
    localparam logic [2:0] E_EARLY_IF  = 3'd4;

    typedef enum logic [1:0] {WAIT_IF, WAIT_ID, SUFFIX, DONE} state_t;

    state_t           state;
    logic [1:0]       exp_stage;
    logic [2:0]       cur_class;
    logic [3:0]       cyc_cnt;
    logic [GAP_W-1:0] gap;
    logic             busy_q, retire_q, err_q;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       class_q, code_q;
    logic [3:0]       cpi_q;

    logic [4:0] strb, exp_vec;
    logic       open_c, multi_c, early_c, bad_c, tmo_c, err_c, final_c;
    logic [2:0] code_c, dec_class;
    logic [1:0] next_stage;
    logic [3:0] cnt_inc;

    // MIPS opcode/funct decode into stage-sequence classes
    function automatic logic [2:0] decode(input logic [5:0] op, input logic [5:0] fn);
        logic [2:0] c;
        case (op)
            6'h00:                             c = (fn == 6'h08) ? CL_BRANCH : CL_ALU;
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: c = CL_BRANCH;
            6'h02:                             c = CL_JUMP;
            6'h03, 6'h08, 6'h09, 6'h0A,
            6'h0B, 6'h0C, 6'h0D, 6'h0E:        c = CL_ALU;
            6'h0F:                             c = CL_LUI;
            6'h28, 6'h29, 6'h2B:               c = CL_STORE;
            default:                           c = CL_LOAD;
        endcase
        return c;
    endfunction

    always_comb begin
        strb      = {bus.wb_clk, bus.mem_clk, bus.ex_clk, bus.id_clk, bus.if_clk};
        dec_class = decode(bus.op_code, bus.funct);
        cnt_inc   = (cyc_cnt == 4'hF) ? 4'hF : cyc_cnt + 4'd1;
        open_c    = (state == WAIT_ID) || (state == SUFFIX);
        exp_vec   = 5'b00001;
        case (state)
            WAIT_ID: exp_vec = 5'b00010;
            SUFFIX:  exp_vec = (exp_stage == ST_EX)  ? 5'b00100 :
                               (exp_stage == ST_MEM) ? 5'b01000 : 5'b10000;
            default: exp_vec = 5'b00001;
        endcase
        // Successor of the stage just seen within the current class; final_c ends the suffix
        final_c    = 1'b1;
        next_stage = ST_WB;
        case (cur_class)
            CL_LOAD:  begin final_c = (exp_stage == ST_WB);  next_stage = (exp_stage == ST_EX) ? ST_MEM : ST_WB; end
            CL_STORE: begin final_c = (exp_stage == ST_MEM); next_stage = ST_MEM; end
            CL_ALU:   begin final_c = (exp_stage == ST_WB);  next_stage = ST_WB; end
            default:  begin final_c = 1'b1;                  next_stage = ST_WB; end
        endcase
        multi_c = (strb & (strb - 5'd1)) != 5'd0;
        early_c = open_c && bus.if_clk;
        bad_c   = (strb != 5'd0) && (strb != exp_vec);
        tmo_c   = open_c && (strb == 5'd0) && (gap == GAP_W'(TIMEOUT - 1));
        err_c   = multi_c || early_c || bad_c || tmo_c;
        code_c  = multi_c ? E_MULTI_HOT :
                  early_c ? E_EARLY_IF  :
                  bad_c   ? E_BAD_ORDER : E_TIMEOUT;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= WAIT_IF;
            exp_stage <= ST_EX;
            cur_class <= CL_LOAD;
            cyc_cnt   <= 4'd0;
            gap       <= '0;
            busy_q    <= 1'b0;
            retire_q  <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
            class_q   <= 3'd0;
            code_q    <= 3'd0;
            cpi_q     <= 4'd0;
        end else begin
            retire_q <= 1'b0;
            if (err_c) begin
                err_q <= 1'b1;
                if (code_q == 3'd0) code_q <= code_c;
                gap <= '0;
                // An early IF is itself the start of a new instruction
                if (early_c && !multi_c) begin
                    state   <= WAIT_ID;
                    cyc_cnt <= 4'd1;
                    busy_q  <= 1'b1;
                end else begin
                    state  <= WAIT_IF;
                    busy_q <= 1'b0;
                end
            end else begin
                case (state)
                    WAIT_IF, DONE: begin
                        if (bus.if_clk) begin
                            state   <= WAIT_ID;
                            cyc_cnt <= 4'd1;
                            gap     <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            state <= WAIT_IF;
                        end
                    end
                    WAIT_ID: begin
                        cyc_cnt <= cnt_inc;
                        if (bus.id_clk) begin
                            gap       <= '0;
                            class_q   <= dec_class;
                            cur_class <= dec_class;
                            if (dec_class == CL_JUMP) begin
                                state    <= DONE;
                                busy_q   <= 1'b0;
                                retire_q <= 1'b1;
                                count_q  <= count_q + CNT_W'(1);
                                cpi_q    <= cnt_inc;
                            end else begin
                                state     <= SUFFIX;
                                exp_stage <= (dec_class == CL_LUI) ? ST_WB : ST_EX;
                            end
                        end else begin
                            gap <= gap + GAP_W'(1);
                        end
                    end
                    SUFFIX: begin
                        cyc_cnt <= cnt_inc;
                        if (strb == exp_vec) begin
                            gap <= '0;
                            if (final_c) begin
                                state    <= DONE;
                                busy_q   <= 1'b0;
                                retire_q <= 1'b1;
                                count_q  <= count_q + CNT_W'(1);
                                cpi_q    <= cnt_inc;
                            end else begin
                                exp_stage <= next_stage;
                            end
                        end else begin
                            gap <= gap + GAP_W'(1);
                        end
                    end
                    default: state <= WAIT_IF;
                endcase
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.retire       = retire_q;
    assign bus.retire_count = count_q;
    assign bus.inst_class   = class_q;
    assign bus.last_cpi     = cpi_q;
    assign bus.err          = err_q;
    assign bus.err_code     = code_q;
endmodule
